// File: rtl/windowed_bin_accumulator.sv
// -----------------------------------------------------------------------------
// windowed_bin_accumulator
//
// Multi-bin sliding-window accumulator for signed event positions. Events are
// summed into a live bin that closes every CYCLES_PER_BIN cycles and is pushed
// into a ring of NUM_BINS completed bins. At each bin boundary the early (older
// half) and late (newer half) running totals are updated incrementally by
// add-new / subtract-old, so downstream sees one update per bin.
//
// Ports:
//   clk            : clock
//   rst_n          : asynchronous active-low reset, clears all state
//   clear          : synchronous flush, same effect as reset, highest priority
//   event_valid    : event strobe (accepted every cycle, no backpressure)
//   event_x/_y     : signed event coordinates, GRID_BITS+1 bits
//   event_polarity : 1 = ON, 0 = OFF
//   bin_tick       : high in the bin-closing (rollover) cycle
//   bin_ptr        : ring index of the oldest completed bin
//   window_filled  : NUM_BINS bins completed since reset/clear
//   early_sum_x/_y, late_sum_x/_y       : running signed half-window sums
//   early_count, late_count             : running half-window event counts
//   early_count_on, late_count_on       : running half-window ON counts
//   accum_valid    : one-cycle pulse when the totals hold a new update
// -----------------------------------------------------------------------------
module windowed_bin_accumulator #(
    parameter int GRID_BITS      = 4,
    parameter int SUM_BITS       = 18,
    parameter int COUNT_BITS     = 12,
    parameter int NUM_BINS       = 4,
    parameter int CYCLES_PER_BIN = 1_200_000,
    parameter int TIMER_BITS     = 21,
    parameter int OUT_SUM_BITS   = SUM_BITS + $clog2(NUM_BINS),
    parameter int OUT_COUNT_BITS = COUNT_BITS + $clog2(NUM_BINS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             event_valid,
    input  logic signed [GRID_BITS:0]        event_x,
    input  logic signed [GRID_BITS:0]        event_y,
    input  logic                             event_polarity,
    output logic                             bin_tick,
    output logic [$clog2(NUM_BINS)-1:0]      bin_ptr,
    output logic                             window_filled,
    output logic signed [OUT_SUM_BITS-1:0]   early_sum_x,
    output logic signed [OUT_SUM_BITS-1:0]   early_sum_y,
    output logic signed [OUT_SUM_BITS-1:0]   late_sum_x,
    output logic signed [OUT_SUM_BITS-1:0]   late_sum_y,
    output logic [OUT_COUNT_BITS-1:0]        early_count,
    output logic [OUT_COUNT_BITS-1:0]        late_count,
    output logic [OUT_COUNT_BITS-1:0]        early_count_on,
    output logic [OUT_COUNT_BITS-1:0]        late_count_on,
    output logic                             accum_valid
);

    localparam int PTR_W   = $clog2(NUM_BINS);
    localparam int FILL_W  = PTR_W + 1;
    localparam int COORD_W = GRID_BITS + 1;

    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(CYCLES_PER_BIN - 1);
    localparam logic [PTR_W-1:0]      HALF_IDX   = PTR_W'(NUM_BINS / 2);
    localparam logic [FILL_W-1:0]     FILL_FULL  = FILL_W'(NUM_BINS);

    localparam logic signed [SUM_BITS-1:0] SUM_MAX   = {1'b0, {(SUM_BITS-1){1'b1}}};
    localparam logic signed [SUM_BITS-1:0] SUM_MIN   = {1'b1, {(SUM_BITS-1){1'b0}}};
    localparam logic [COUNT_BITS-1:0]      COUNT_MAX = {COUNT_BITS{1'b1}};

    // -------------------------------------------------------------------------
    // Saturation and widening helpers
    // -------------------------------------------------------------------------
    // Signed add clamped to the SUM_BITS range; overflow is detected by the
    // guard bit disagreeing with the result sign bit.
    function automatic logic signed [SUM_BITS-1:0] sat_add_sum(
        input logic signed [SUM_BITS-1:0] a,
        input logic signed [SUM_BITS-1:0] b
    );
        logic signed [SUM_BITS:0] wide;
        wide = {a[SUM_BITS-1], a} + {b[SUM_BITS-1], b};
        if (wide[SUM_BITS] != wide[SUM_BITS-1]) begin
            sat_add_sum = wide[SUM_BITS] ? SUM_MIN : SUM_MAX;
        end else begin
            sat_add_sum = wide[SUM_BITS-1:0];
        end
    endfunction

    // Count increment that sticks at the all-ones maximum.
    function automatic logic [COUNT_BITS-1:0] sat_inc_count(
        input logic [COUNT_BITS-1:0] c
    );
        if (c == COUNT_MAX) begin
            sat_inc_count = c;
        end else begin
            sat_inc_count = c + COUNT_BITS'(1);
        end
    endfunction

    function automatic logic signed [OUT_SUM_BITS-1:0] widen_sum(
        input logic signed [SUM_BITS-1:0] v
    );
        widen_sum = {{(OUT_SUM_BITS-SUM_BITS){v[SUM_BITS-1]}}, v};
    endfunction

    function automatic logic [OUT_COUNT_BITS-1:0] widen_count(
        input logic [COUNT_BITS-1:0] v
    );
        widen_count = {{(OUT_COUNT_BITS-COUNT_BITS){1'b0}}, v};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [TIMER_BITS-1:0]         timer;
    logic [FILL_W-1:0]             fill_cnt;

    logic signed [SUM_BITS-1:0]    live_sum_x;
    logic signed [SUM_BITS-1:0]    live_sum_y;
    logic [COUNT_BITS-1:0]         live_count;
    logic [COUNT_BITS-1:0]         live_count_on;

    logic signed [SUM_BITS-1:0]    ring_sum_x    [NUM_BINS];
    logic signed [SUM_BITS-1:0]    ring_sum_y    [NUM_BINS];
    logic [COUNT_BITS-1:0]         ring_count    [NUM_BINS];
    logic [COUNT_BITS-1:0]         ring_count_on [NUM_BINS];

    // -------------------------------------------------------------------------
    // Combinational next values
    // -------------------------------------------------------------------------
    logic                          rollover;
    logic [PTR_W-1:0]              mid_idx;
    logic signed [SUM_BITS-1:0]    ev_x_ext;
    logic signed [SUM_BITS-1:0]    ev_y_ext;

    logic signed [SUM_BITS-1:0]    live_sum_x_add;
    logic signed [SUM_BITS-1:0]    live_sum_y_add;
    logic [COUNT_BITS-1:0]         live_count_add;
    logic [COUNT_BITS-1:0]         live_count_on_add;

    logic signed [OUT_SUM_BITS-1:0] early_sum_x_nxt;
    logic signed [OUT_SUM_BITS-1:0] early_sum_y_nxt;
    logic signed [OUT_SUM_BITS-1:0] late_sum_x_nxt;
    logic signed [OUT_SUM_BITS-1:0] late_sum_y_nxt;
    logic [OUT_COUNT_BITS-1:0]      early_count_nxt;
    logic [OUT_COUNT_BITS-1:0]      late_count_nxt;
    logic [OUT_COUNT_BITS-1:0]      early_count_on_nxt;
    logic [OUT_COUNT_BITS-1:0]      late_count_on_nxt;

    assign rollover      = (timer == TIMER_LAST);
    assign bin_tick      = rollover;
    assign window_filled = (fill_cnt == FILL_FULL);

    // Oldest bin of the newer half: it crosses from late to early at rollover.
    assign mid_idx  = bin_ptr + HALF_IDX;

    assign ev_x_ext = {{(SUM_BITS-COORD_W){event_x[COORD_W-1]}}, event_x};
    assign ev_y_ext = {{(SUM_BITS-COORD_W){event_y[COORD_W-1]}}, event_y};

    always_comb begin
        live_sum_x_add    = sat_add_sum(live_sum_x, ev_x_ext);
        live_sum_y_add    = sat_add_sum(live_sum_y, ev_y_ext);
        live_count_add    = sat_inc_count(live_count);
        live_count_on_add = event_polarity ? sat_inc_count(live_count_on) : live_count_on;
    end

    // Incremental window update. Stored (already saturated) bin values are the
    // ones subtracted, so the totals always equal the sum of the ring halves and
    // the wider output width can never overflow.
    always_comb begin
        early_sum_x_nxt    = early_sum_x - widen_sum(ring_sum_x[bin_ptr])
                                         + widen_sum(ring_sum_x[mid_idx]);
        early_sum_y_nxt    = early_sum_y - widen_sum(ring_sum_y[bin_ptr])
                                         + widen_sum(ring_sum_y[mid_idx]);
        early_count_nxt    = early_count - widen_count(ring_count[bin_ptr])
                                         + widen_count(ring_count[mid_idx]);
        early_count_on_nxt = early_count_on - widen_count(ring_count_on[bin_ptr])
                                            + widen_count(ring_count_on[mid_idx]);
        late_sum_x_nxt     = late_sum_x - widen_sum(ring_sum_x[mid_idx])
                                        + widen_sum(live_sum_x);
        late_sum_y_nxt     = late_sum_y - widen_sum(ring_sum_y[mid_idx])
                                        + widen_sum(live_sum_y);
        late_count_nxt     = late_count - widen_count(ring_count[mid_idx])
                                        + widen_count(live_count);
        late_count_on_nxt  = late_count_on - widen_count(ring_count_on[mid_idx])
                                           + widen_count(live_count_on);
    end

    // -------------------------------------------------------------------------
    // Sequential state: timer, live bin, ring and running totals
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer          <= '0;
            fill_cnt       <= '0;
            bin_ptr        <= '0;
            accum_valid    <= 1'b0;
            live_sum_x     <= '0;
            live_sum_y     <= '0;
            live_count     <= '0;
            live_count_on  <= '0;
            early_sum_x    <= '0;
            early_sum_y    <= '0;
            late_sum_x     <= '0;
            late_sum_y     <= '0;
            early_count    <= '0;
            late_count     <= '0;
            early_count_on <= '0;
            late_count_on  <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
                ring_sum_x[i]    <= '0;
                ring_sum_y[i]    <= '0;
                ring_count[i]    <= '0;
                ring_count_on[i] <= '0;
            end
        end else if (clear) begin
            // Flush beats a coincident rollover and drops a coincident event.
            timer          <= '0;
            fill_cnt       <= '0;
            bin_ptr        <= '0;
            accum_valid    <= 1'b0;
            live_sum_x     <= '0;
            live_sum_y     <= '0;
            live_count     <= '0;
            live_count_on  <= '0;
            early_sum_x    <= '0;
            early_sum_y    <= '0;
            late_sum_x     <= '0;
            late_sum_y     <= '0;
            early_count    <= '0;
            late_count     <= '0;
            early_count_on <= '0;
            late_count_on  <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
                ring_sum_x[i]    <= '0;
                ring_sum_y[i]    <= '0;
                ring_count[i]    <= '0;
                ring_count_on[i] <= '0;
            end
        end else begin
            accum_valid <= rollover;

            if (rollover) begin
                timer <= '0;

                // Stage 0 -> 1: the closing live bin replaces the oldest ring
                // entry; an event in this cycle seeds the next live bin.
                ring_sum_x[bin_ptr]    <= live_sum_x;
                ring_sum_y[bin_ptr]    <= live_sum_y;
                ring_count[bin_ptr]    <= live_count;
                ring_count_on[bin_ptr] <= live_count_on;

                if (event_valid) begin
                    live_sum_x    <= ev_x_ext;
                    live_sum_y    <= ev_y_ext;
                    live_count    <= COUNT_BITS'(1);
                    live_count_on <= COUNT_BITS'(event_polarity);
                end else begin
                    live_sum_x    <= '0;
                    live_sum_y    <= '0;
                    live_count    <= '0;
                    live_count_on <= '0;
                end

                // Stage 1 -> output: running totals, visible with accum_valid.
                early_sum_x    <= early_sum_x_nxt;
                early_sum_y    <= early_sum_y_nxt;
                late_sum_x     <= late_sum_x_nxt;
                late_sum_y     <= late_sum_y_nxt;
                early_count    <= early_count_nxt;
                late_count     <= late_count_nxt;
                early_count_on <= early_count_on_nxt;
                late_count_on  <= late_count_on_nxt;

                bin_ptr <= bin_ptr + PTR_W'(1);
                if (fill_cnt != FILL_FULL) begin
                    fill_cnt <= fill_cnt + FILL_W'(1);
                end
            end else begin
                timer <= timer + TIMER_BITS'(1);
                if (event_valid) begin
                    live_sum_x    <= live_sum_x_add;
                    live_sum_y    <= live_sum_y_add;
                    live_count    <= live_count_add;
                    live_count_on <= live_count_on_add;
                end
            end
        end
    end

endmodule

// File: tb/tb_windowed_bin_accumulator.sv
module tb_windowed_bin_accumulator;

    localparam int GB   = 4;
    localparam int SB   = 7;
    localparam int CB   = 3;
    localparam int NB   = 4;
    localparam int CPB  = 8;
    localparam int TB   = 3;
    localparam int OSB  = SB + 2;
    localparam int OCB  = CB + 2;
    localparam int CW   = GB + 1;
    localparam int SMAX = 63;
    localparam int SMIN = -64;
    localparam int CMAX = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  clear;
    logic                  event_valid;
    logic signed [CW-1:0]  event_x;
    logic signed [CW-1:0]  event_y;
    logic                  event_polarity;
    logic                  bin_tick;
    logic [1:0]            bin_ptr;
    logic                  window_filled;
    logic signed [OSB-1:0] early_sum_x, early_sum_y, late_sum_x, late_sum_y;
    logic [OCB-1:0]        early_count, late_count, early_count_on, late_count_on;
    logic                  accum_valid;

    windowed_bin_accumulator #(
        .GRID_BITS(GB), .SUM_BITS(SB), .COUNT_BITS(CB), .NUM_BINS(NB),
        .CYCLES_PER_BIN(CPB), .TIMER_BITS(TB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .event_valid(event_valid),
        .event_x(event_x), .event_y(event_y), .event_polarity(event_polarity),
        .bin_tick(bin_tick), .bin_ptr(bin_ptr), .window_filled(window_filled),
        .early_sum_x(early_sum_x), .early_sum_y(early_sum_y),
        .late_sum_x(late_sum_x), .late_sum_y(late_sum_y),
        .early_count(early_count), .late_count(late_count),
        .early_count_on(early_count_on), .late_count_on(late_count_on),
        .accum_valid(accum_valid)
    );

    logic [63:0] all_out;
    logic [63:0] all_tot;
    assign all_out = 64'({early_sum_x, early_sum_y, late_sum_x, late_sum_y,
                          early_count, late_count, early_count_on, late_count_on,
                          bin_ptr, window_filled, accum_valid});
    assign all_tot = 64'({early_sum_x, early_sum_y, late_sum_x, late_sum_y,
                          early_count, late_count, early_count_on, late_count_on});

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a list of the last NB completed bins (oldest first),
    // totals recomputed from scratch as plain sums over each half.
    typedef struct {
        int sx;
        int sy;
        int cnt;
        int con;
    } bin_t;

    bin_t hist[$];
    bin_t live;
    int   phase;
    int   m_ptr;
    int   m_fill;
    bit   m_valid;

    function automatic int sat_s(int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic int sat_c(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void model_clear();
        bin_t z;
        z = '{0, 0, 0, 0};
        hist.delete();
        for (int i = 0; i < NB; i++) hist.push_back(z);
        live    = z;
        phase   = 0;
        m_ptr   = 0;
        m_fill  = 0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_edge(bit v, int x, int y, bit p, bit clr);
        bin_t nb;
        if (clr) begin
            model_clear();
            return;
        end
        m_valid = 1'b0;
        if (phase == CPB - 1) begin
            hist.push_back(live);
            void'(hist.pop_front());
            nb   = v ? '{x, y, 1, int'(p)} : '{0, 0, 0, 0};
            live = nb;
            phase = 0;
            m_valid = 1'b1;
            m_ptr = (m_ptr + 1) % NB;
            if (m_fill < NB) m_fill++;
        end else begin
            if (v) begin
                live.sx  = sat_s(live.sx + x);
                live.sy  = sat_s(live.sy + y);
                live.cnt = sat_c(live.cnt + 1);
                if (p) live.con = sat_c(live.con + 1);
            end
            phase++;
        end
    endfunction

    function automatic int half_sum(int first, int field);
        int s = 0;
        for (int i = first; i < first + NB / 2; i++) begin
            case (field)
                0:       s += hist[i].sx;
                1:       s += hist[i].sy;
                2:       s += hist[i].cnt;
                default: s += hist[i].con;
            endcase
        end
        return s;
    endfunction

    task automatic step(input bit v, input int x, input int y, input bit p, input bit clr);
        event_valid    = v;
        event_x        = CW'(x);
        event_y        = CW'(y);
        event_polarity = p;
        clear          = clr;
        @(posedge clk);
        model_edge(v, x, y, p, clr);
        #1;
        event_valid = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int first;
        rst_n = 1'b0; clear = 1'b0; event_valid = 1'b0;
        event_x = '0; event_y = '0; event_polarity = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (all_out !== 64'd0) begin
            n_err++; $display("FAIL reset_init: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 10; i++) step(1'b1, i - 3, 2, i[0], 1'b0);
        n_cmp++;
        if (32'(late_count) !== 7) begin
            n_err++; $display("FAIL reset_state_late_count: got %0d expected 7", late_count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== 64'd0) begin
            n_err++; $display("FAIL reset_async: got %h expected 0", all_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            step(1'b0, 0, 0, 1'b0, 1'b0);
            if (accum_valid === 1'b1) first = i;
        end
        n_cmp++;
        if (first !== 8) begin
            n_err++; $display("FAIL reset_first_valid: got cycle %0d expected 8", first);
        end
        n_cmp++;
        if (all_tot !== 64'd0) begin
            n_err++; $display("FAIL reset_first_totals: got %h expected 0", all_tot);
        end
    endtask

    task automatic test_slide();
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 3, -2, 1'b1, 1'b0);
        idle(7);
        n_cmp++;
        if (accum_valid !== 1'b1) begin
            n_err++; $display("FAIL slide_valid: got %0b expected 1", accum_valid);
        end
        n_cmp++;
        if (32'(late_sum_x) !== 3) begin
            n_err++; $display("FAIL slide_late_x: got %0d expected 3", late_sum_x);
        end
        n_cmp++;
        if (32'(late_sum_y) !== -2) begin
            n_err++; $display("FAIL slide_late_y: got %0d expected -2", late_sum_y);
        end
        n_cmp++;
        if (32'(late_count) !== 1 || 32'(late_count_on) !== 1) begin
            n_err++; $display("FAIL slide_late_counts: got %0d/%0d expected 1/1", late_count, late_count_on);
        end
        n_cmp++;
        if (32'(early_count) !== 0 || 32'(bin_ptr) !== 1) begin
            n_err++; $display("FAIL slide_early_ptr: got %0d/%0d expected 0/1", early_count, bin_ptr);
        end
        idle(16);
        n_cmp++;
        if (32'(early_sum_x) !== 3 || 32'(early_sum_y) !== -2 || 32'(early_count_on) !== 1) begin
            n_err++; $display("FAIL slide_early: got %0d,%0d,%0d expected 3,-2,1", early_sum_x, early_sum_y, early_count_on);
        end
        n_cmp++;
        if (32'(late_count) !== 0 || 32'(late_sum_x) !== 0) begin
            n_err++; $display("FAIL slide_late_empty: got %0d,%0d expected 0,0", late_count, late_sum_x);
        end
        idle(16);
        n_cmp++;
        if (all_tot !== 64'd0) begin
            n_err++; $display("FAIL slide_aged_out: got %h expected 0", all_tot);
        end
    endtask

    task automatic test_rollover_event();
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(7);
        n_cmp++;
        if (bin_tick !== 1'b1) begin
            n_err++; $display("FAIL rollev_tick: got %0b expected 1", bin_tick);
        end
        step(1'b1, -8, 7, 1'b0, 1'b0);
        n_cmp++;
        if (accum_valid !== 1'b1 || 32'(late_count) !== 0) begin
            n_err++; $display("FAIL rollev_absent: got valid %0b count %0d expected 1,0", accum_valid, late_count);
        end
        idle(8);
        n_cmp++;
        if (32'(late_sum_x) !== -8 || 32'(late_sum_y) !== 7) begin
            n_err++; $display("FAIL rollev_sums: got %0d,%0d expected -8,7", late_sum_x, late_sum_y);
        end
        n_cmp++;
        if (32'(late_count) !== 1 || 32'(late_count_on) !== 0) begin
            n_err++; $display("FAIL rollev_counts: got %0d/%0d expected 1/0", late_count, late_count_on);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(7);
        // Ten back-to-back strobes from a rollover cycle: 8 land in one bin.
        for (int i = 0; i < 9; i++) step(1'b1, 15, -16, 1'b1, 1'b0);
        n_cmp++;
        if (32'(late_count) !== 7 || 32'(late_count_on) !== 7) begin
            n_err++; $display("FAIL sat_count: got %0d/%0d expected 7/7", late_count, late_count_on);
        end
        n_cmp++;
        if (32'(late_sum_x) !== 63 || 32'(late_sum_y) !== -64) begin
            n_err++; $display("FAIL sat_sums: got %0d,%0d expected 63,-64", late_sum_x, late_sum_y);
        end
        step(1'b1, 15, -16, 1'b1, 1'b0);
        idle(7);
        n_cmp++;
        if (32'(late_count) !== 9 || 32'(late_sum_x) !== 93 || 32'(late_sum_y) !== -96) begin
            n_err++; $display("FAIL sat_two_bins: got %0d,%0d,%0d expected 9,93,-96", late_count, late_sum_x, late_sum_y);
        end
        idle(32);
        n_cmp++;
        if (all_tot !== 64'd0 || 32'(bin_ptr) !== 3) begin
            n_err++; $display("FAIL sat_drain: got %h ptr %0d expected 0 ptr 3", all_tot, bin_ptr);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 48; i++) begin
            step(1'b1, int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                 1'($urandom_range(0, 1)), 1'b0);
            if (i == 32) begin
                n_cmp++;
                if (window_filled !== 1'b1) begin
                    n_err++; $display("FAIL flush_filled_first: got %0b expected 1", window_filled);
                end
            end
        end
        idle(7);
        step(1'b1, 5, 5, 1'b1, 1'b1);
        n_cmp++;
        if (all_out !== 64'd0) begin
            n_err++; $display("FAIL flush_zero: got %h expected 0", all_out);
        end
        idle(8);
        n_cmp++;
        if (accum_valid !== 1'b1 || 32'(late_count) !== 0) begin
            n_err++; $display("FAIL flush_event_dropped: got valid %0b count %0d expected 1,0", accum_valid, late_count);
        end
        idle(16);
        n_cmp++;
        if (window_filled !== 1'b0) begin
            n_err++; $display("FAIL flush_not_filled: got %0b expected 0", window_filled);
        end
        idle(8);
        n_cmp++;
        if (window_filled !== 1'b1) begin
            n_err++; $display("FAIL flush_refilled: got %0b expected 1", window_filled);
        end
    endtask

    task automatic test_random();
        bit v, p, clr;
        int x, y;
        step(1'b0, 0, 0, 1'b0, 1'b1);
        for (int n = 0; n < 1000 * CPB; n++) begin
            v   = ($urandom_range(0, 99) < 70);
            p   = 1'($urandom_range(0, 1));
            x   = int'($urandom_range(0, 31)) - 16;
            y   = int'($urandom_range(0, 31)) - 16;
            clr = ($urandom_range(0, 599) == 0);
            n_cmp++;
            if (bin_tick !== (phase == CPB - 1)) begin
                n_err++; $display("FAIL rnd_tick: got %0b expected %0b", bin_tick, phase == CPB - 1);
            end
            step(v, x, y, p, clr);
            n_cmp++;
            if (accum_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_valid: got %0b expected %0b", accum_valid, m_valid);
            end
            if (m_valid) begin
                n_cmp++;
                if (32'(early_sum_x) !== half_sum(0, 0) || 32'(early_sum_y) !== half_sum(0, 1)) begin
                    n_err++; $display("FAIL rnd_early_sums: got %0d,%0d expected %0d,%0d",
                                      early_sum_x, early_sum_y, half_sum(0, 0), half_sum(0, 1));
                end
                n_cmp++;
                if (32'(late_sum_x) !== half_sum(2, 0) || 32'(late_sum_y) !== half_sum(2, 1)) begin
                    n_err++; $display("FAIL rnd_late_sums: got %0d,%0d expected %0d,%0d",
                                      late_sum_x, late_sum_y, half_sum(2, 0), half_sum(2, 1));
                end
                n_cmp++;
                if (32'(early_count) !== half_sum(0, 2) || 32'(early_count_on) !== half_sum(0, 3)) begin
                    n_err++; $display("FAIL rnd_early_counts: got %0d,%0d expected %0d,%0d",
                                      early_count, early_count_on, half_sum(0, 2), half_sum(0, 3));
                end
                n_cmp++;
                if (32'(late_count) !== half_sum(2, 2) || 32'(late_count_on) !== half_sum(2, 3)) begin
                    n_err++; $display("FAIL rnd_late_counts: got %0d,%0d expected %0d,%0d",
                                      late_count, late_count_on, half_sum(2, 2), half_sum(2, 3));
                end
                n_cmp++;
                if (32'(bin_ptr) !== m_ptr || window_filled !== (m_fill == NB)) begin
                    n_err++; $display("FAIL rnd_ptr_fill: got %0d,%0b expected %0d,%0b",
                                      bin_ptr, window_filled, m_ptr, m_fill == NB);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_slide();
        test_rollover_event();
        test_saturation();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
